// File: rtl/usrt_tx_engine.sv
// Buffered USRT transmitter: a small FIFO of bytes from the APB write path,
// framed as 11-bit words and shifted out LSB-first on each baud tick.
module usrt_tx_engine #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          pClk,
    input  logic          pReset,
    input  logic          uClk,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          ovf_clr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          busy,
    output logic          frame_done,
    output logic          line_out
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   cntNext;
    logic [10:0]   shReg;
    logic [3:0]    bitIdx;
    logic          push, pop, drop;
    logic [7:0]    headByte;

    // full is the registered flag, so a same-cycle pop never rescues a write
    assign push     = wr_en & ~full;
    assign drop     = wr_en & full;
    assign pop      = (state == IDLE) & ~empty;
    assign headByte = mem[rdPtr];

    always_comb begin
        cntNext = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge pClk) begin
        if (push) mem[wrPtr] <= wr_data;
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count <= cntNext;
            full  <= (cntNext == (AW+1)'(DEPTH));
            empty <= (cntNext == '0);
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Stop bit (0) stays on the line until the next frame's start tick,
    // giving gapless back-to-back frames and a 0 idle level.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state      <= IDLE;
            shReg      <= '0;
            bitIdx     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_out   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shReg  <= {1'b0, ^headByte, headByte, 1'b1};
                        bitIdx <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (uClk) begin
                        line_out <= shReg[0];
                        shReg    <= shReg >> 1;
                        bitIdx   <= bitIdx + 4'd1;
                        if (bitIdx == 4'd10) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usrt_tx_engine.sv
// Scoreboard bench for usrt_tx_engine: expected line bits are queued per
// accepted byte and popped on each baud tick.
module tb_usrt_tx_engine;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int GAP   = 79;

    logic          pClk, pReset, uClk, wr_en, ovf_clr;
    logic [7:0]    wr_data;
    logic          full, empty, overflow, busy, frame_done, line_out;
    logic [AW:0]   count;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    usrt_tx_engine #(.DEPTH(DEPTH), .AW(AW)) dut (
        .pClk(pClk), .pReset(pReset), .uClk(uClk),
        .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .busy(busy), .frame_done(frame_done), .line_out(line_out)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    // expected 11-bit frame, LSB first: start 1, data, parity, stop 0
    task automatic expect_frame(input logic [7:0] d);
        exp_t e;
        logic [10:0] w;
        w = {1'b0, ^d, d, 1'b1};
        for (int i = 0; i < 11; i++) begin
            e.b    = w[i];
            e.last = (i == 10);
            sbq.push_back(e);
        end
    endtask

    // one baud tick after GAP idle cycles; compare the shifted bit
    task automatic tick(input string tag);
        exp_t e;
        repeat (GAP) @(negedge pClk);
        uClk = 1'b1;
        @(negedge pClk);
        uClk = 1'b0;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
        end else begin
            e.b    = 1'b0;
            e.last = 1'b0;
        end
        total++;
        if (line_out !== e.b) begin
            bad++;
            $display("FAIL %s line_out: got %b want %b", tag, line_out, e.b);
        end
        total++;
        if (frame_done !== e.last) begin
            bad++;
            $display("FAIL %s frame_done: got %b want %b", tag, frame_done, e.last);
        end
    endtask

    task automatic idle_bus();
        @(negedge pClk);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({full, empty, count, overflow, busy, frame_done, line_out} !== {1'b0, 1'b1, 3'd0, 4'b0000}) begin
            bad++;
            $display("FAIL reset_state: got full=%b empty=%b count=%0d ovf=%b busy=%b fd=%b line=%b want 0 1 0 0 0 0 0",
                     full, empty, count, overflow, busy, frame_done, line_out);
        end
    endtask

    task automatic test_single(input logic [7:0] d, input string tag);
        @(negedge pClk);
        wr_en = 1'b1; wr_data = d;
        expect_frame(d);
        idle_bus();
        for (int i = 0; i < 11; i++) tick(tag);
        total++;
        if (busy !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL %s_end: got busy=%b count=%0d want busy=0 count=0", tag, busy, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 6; i++) begin
            @(negedge pClk);
            if (i == 2) begin
                total++;
                if (count !== 3'd1) begin
                    bad++;
                    $display("FAIL fill_first_pop count: got %0d want 1", count);
                end
            end
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            if (i < 5) expect_frame(8'h10 + 8'(i));
        end
        idle_bus();
        total++;
        if (count !== 3'd4 || full !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL fill_status: got count=%0d full=%b busy=%b want 4 1 1", count, full, busy);
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL fill_overflow: got %b want 1", overflow);
        end
        // drop and clear together: set wins
        @(negedge pClk);
        wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
        idle_bus();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set_wins: got %b want 1", overflow);
        end
        @(negedge pClk);
        ovf_clr = 1'b1;
        idle_bus();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr: got %b want 0", overflow);
        end
        for (int i = 0; i < 55; i++) tick("fill_drain");
        total++;
        if (empty !== 1'b1 || count !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fill_end: got empty=%b count=%0d busy=%b want 1 0 0", empty, count, busy);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 3; i++) begin
            @(negedge pClk);
            wr_en = 1'b1;
            wr_data = (i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : 8'h0F;
        end
        expect_frame(8'hA5);
        idle_bus();
        for (int i = 0; i < 4; i++) tick("rst_pre");
        total++;
        if (line_out !== 1'b1 || busy !== 1'b1 || count !== 3'd2) begin
            bad++;
            $display("FAIL rst_pre_state: got line=%b busy=%b count=%0d want 1 1 2", line_out, busy, count);
        end
        repeat (GAP) @(negedge pClk);
        uClk = 1'b1;
        pReset = 1'b0;
        #1;
        total++;
        if (line_out !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL rst_async: got line=%b busy=%b count=%0d empty=%b want 0 0 0 1",
                     line_out, busy, count, empty);
        end
        sbq.delete();
        @(negedge pClk);
        uClk = 1'b0;
        @(negedge pClk);
        pReset = 1'b1;
        for (int i = 0; i < 3; i++) tick("rst_quiet");
        total++;
        if (busy !== 1'b0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL rst_quiet_state: got busy=%b empty=%b want 0 1", busy, empty);
        end
        test_single(8'h01, "rst_after");
    endtask

    task automatic test_back_to_back();
        @(negedge pClk);
        wr_en = 1'b1; wr_data = 8'h3C;
        expect_frame(8'h3C);
        @(negedge pClk);
        wr_data = 8'hC7;
        expect_frame(8'hC7);
        idle_bus();
        total++;
        if (count !== 3'd1) begin
            bad++;
            $display("FAIL simul_push_pop count: got %0d want 1", count);
        end
        for (int i = 0; i < 22; i++) tick("simul_order");
        total++;
        if (empty !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL simul_end: got empty=%b busy=%b want 1 0", empty, busy);
        end
    endtask

    initial begin
        pReset = 1'b0; uClk = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        repeat (3) @(negedge pClk);
        test_reset();
        pReset = 1'b1;
        test_single(8'hA5, "frame_a5");
        test_single(8'h01, "frame_01");
        test_fill_overflow();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usrt_tx_engine.md
Name: usrt_tx_engine

Overview:
- Transmit-side stage between the APB write path and the USRT serial line.
- Buffers bytes written from the bus in a small FIFO and frames each byte as the 11-bit USRT word: bit0=1, bits8:1=data, bit9=XOR parity of data, bit10=0.
- Shifts the word out LSB-first, one bit per uClk tick from baud_gen.
- Replaces the separate write_reg/serializer pair with a single buffered engine in the pClk domain.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- pClk  in  1  system/APB clock; the only clock.
- pReset  in  1  asynchronous active-low reset.
- uClk  in  1  baud tick from baud_gen; one pClk cycle wide, synchronous to pClk; used as an enable, never as a clock.
- wr_en  in  1  push request from the APB write path (pSelect & pEnable & pWrite & pReady).
- wr_data  in  8  byte to transmit.
- ovf_clr  in  1  clears the sticky overflow flag.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  AW+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was dropped.
- busy  out  1  a frame is loaded or being shifted.
- frame_done  out  1  one-cycle pulse when bit10 of a frame is driven.
- line_out  out  1  serial line (the Rx input of the far side); idle level 0.

Behaviour:
- Reset (pReset=0, async):
  - FIFO pointers and count = 0; full=0; empty=1.
  - overflow=0, busy=0, frame_done=0, line_out=0, state=IDLE, bit index=0.
  - Takes effect immediately, including mid-frame. The frame in progress and all FIFO contents are discarded; no partial frame resumes.
- FIFO:
  - Push: wr_en=1 and full=0 at a pClk edge stores wr_data at the write pointer; the pointer wraps modulo DEPTH.
  - Drop: wr_en=1 while full=1 drops the byte and sets overflow=1. This applies even if a pop occurs in the same cycle; full is the registered value.
  - Overflow priority: overflow clears on ovf_clr=1. A drop in the same cycle as ovf_clr=1 leaves overflow=1 (set wins).
  - Count: simultaneous push and pop leaves count unchanged.
  - Status: full, empty and count are registered and consistent with each other every cycle.
- States (two-state FSM):
  - IDLE:
    - If empty=0, pop the head entry and build the frame into an 11-bit shift register.
    - Set bit index=0, busy=1, go to SHIFT. Pop latency is one cycle after the push becomes visible (write at edge t, pop at edge t+1 at the earliest).
    - If empty=1, stay in IDLE with busy=0. line_out holds its last value.
  - SHIFT:
    - On each pClk edge with uClk=1: line_out <= shreg[index], index++.
    - On the tick that drives index 10: frame_done=1 for that cycle, busy=0, go to IDLE.
    - Edges with uClk=0 change nothing.
- Line timing:
  - Each bit is held for exactly one tick period.
  - Bit10 (0) is held until the next frame's bit0 tick, so queued frames go out back-to-back with no gap ticks.
  - With no data queued, the line stays at 0.
- Parity: bit9 = ^wr_data (even-parity XOR of the 8 data bits), computed at pop time.
- uClk ticks arriving in IDLE are ignored. The first bit of a new frame is driven on the first tick after entry to SHIFT.
- Writes have no effect on a frame already in SHIFT.

Test Plan:
- Write 0xA5, uClk every 80 cycles -> on successive ticks line_out = 1,1,0,1,0,0,1,0,1,0,0. frame_done pulses on the 11th tick; busy then falls; count returns to 0.
- Write 0x01 -> line_out = 1,1,0,0,0,0,0,0,0,1,0 (parity bit = 1).
- Six back-to-back writes 0x10..0x15 with uClk held 0:
  - First byte popped into the shift register; count=4, full=1.
  - 0x15 dropped; overflow=1.
  - ovf_clr -> overflow=0.
- Enable ticks after the fill -> 5 frames (0x10..0x14) on consecutive 11-tick windows with no idle tick between them. 0x15 never appears; empty=1 at the end.
- Assert pReset=0 on the 5th tick of a frame with 2 bytes queued -> line_out=0, busy=0, count=0 asynchronously. After release, no activity occurs until a new write.
- Simultaneous write and pop with count=1 -> count stays 1, data order is preserved (FIFO order verified by the line sequence).
